xbar_slave_arbiter: RTL and testbench

//  Per-slave arbitration stage of the cross bar. Sits between NUM_MASTERS master ports and one slave port.

---
 rtl/xbar_pkg.sv | 16 +
 rtl/xbar_rr_arbiter.sv | 27 ++
 rtl/xbar_slave_arbiter.sv | 116 +++++++++++
 tb/tb_xbar_slave_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared constants and types for the crossbar slave-side arbitration stage.
package xbar_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int SLV_ID_MSB = 31;
  localparam int SLV_ID_LSB = 28;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Combinational round-robin pick: first eligible master at or after ptr, wrapping.
module xbar_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] grant
);

  // Scan from the farthest offset down so the closest eligible master wins last.
  always_comb begin
    int idx;
    idx   = 0;
    valid = 1'b0;
    grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[idx]) begin
        valid = 1'b1;
        grant = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbitration stage: round-robin grant of address-matched masters onto one slave port,
// with a watchdog that force-completes a transaction the slave never acknowledges.
module xbar_slave_arbiter
  import xbar_pkg::*;
#(
  parameter int         NUM_MASTERS = 4,
  parameter logic [3:0] SLAVE_ID    = 4'd0,
  parameter int         TIMEOUT     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS-1:0]               m_s_req,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_s_addr,
  input  logic [NUM_MASTERS-1:0]               m_s_cmd,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_s_wdata,
  output logic [NUM_MASTERS-1:0]               s_m_ack,
  output logic [DATA_W-1:0]                    s_m_rdata,
  output logic                                 sl_req,
  output logic [ADDR_W-1:0]                    sl_addr,
  output logic                                 sl_cmd,
  output logic [DATA_W-1:0]                    sl_wdata,
  input  logic                                 sl_ack,
  input  logic [DATA_W-1:0]                    sl_rdata,
  output logic                                 timeout,
  output logic                                 dbg_state,
  output logic [$clog2(NUM_MASTERS)-1:0]       dbg_ptr
);

  localparam int               PTR_W    = $clog2(NUM_MASTERS);
  localparam int               WD_W     = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);

  arb_state_t             state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       grant;
  logic [PTR_W-1:0]       pick;
  logic                   pick_valid;
  logic [WD_W-1:0]        wd;
  logic                   done;
  logic [NUM_MASTERS-1:0] eligible;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = m_s_req[i] && (m_s_addr[i][SLV_ID_MSB:SLV_ID_LSB] == SLAVE_ID);
    end
  end

  xbar_rr_arbiter #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pick_valid),
    .grant    (pick)
  );

  // A real ack on the watchdog's last cycle takes precedence over the forced completion.
  assign done = (state == BUSY) && (sl_ack || (wd == WD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      wd       <= '0;
      sl_req   <= 1'b0;
      sl_addr  <= '0;
      sl_cmd   <= CMD_READ;
      sl_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick;
            sl_req   <= 1'b1;
            sl_addr  <= m_s_addr[pick];
            sl_cmd   <= m_s_cmd[pick];
            sl_wdata <= m_s_wdata[pick];
            wd       <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            sl_req <= 1'b0;
            wd     <= '0;
            ptr    <= (grant == PTR_LAST) ? '0 : grant + PTR_W'(1);
            state  <= IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path is combinational so the master sees the slave's data in the ack cycle.
  always_comb begin
    s_m_ack   = '0;
    s_m_rdata = '0;
    timeout   = 1'b0;
    if (done) begin
      s_m_ack[grant] = 1'b1;
      s_m_rdata      = sl_ack ? sl_rdata : TIMEOUT_RDATA;
      timeout        = !sl_ack;
    end
  end

  assign dbg_state = (state == BUSY);
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter: directed scenarios plus random masters/slave against a
// transaction-level reference model and a grant-order scoreboard.
module tb_xbar_slave_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       m_s_req   = '0;
  logic [N-1:0][31:0] m_s_addr  = '0;
  logic [N-1:0]       m_s_cmd   = '0;
  logic [N-1:0][31:0] m_s_wdata = '0;
  logic [N-1:0]       s_m_ack;
  logic [31:0]        s_m_rdata;
  logic               sl_req;
  logic [31:0]        sl_addr;
  logic               sl_cmd;
  logic [31:0]        sl_wdata;
  logic               sl_ack   = 1'b0;
  logic [31:0]        sl_rdata = '0;
  logic               timeout;
  logic               dbg_state;
  logic [1:0]         dbg_ptr;

  xbar_slave_arbiter #(
    .NUM_MASTERS (N),
    .SLAVE_ID    (4'd0),
    .TIMEOUT     (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_s_req   (m_s_req),
    .m_s_addr  (m_s_addr),
    .m_s_cmd   (m_s_cmd),
    .m_s_wdata (m_s_wdata),
    .s_m_ack   (s_m_ack),
    .s_m_rdata (s_m_rdata),
    .sl_req    (sl_req),
    .sl_addr   (sl_addr),
    .sl_cmd    (sl_cmd),
    .sl_wdata  (sl_wdata),
    .sl_ack    (sl_ack),
    .sl_rdata  (sl_rdata),
    .timeout   (timeout),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]       req_r   = '0;
  logic [N-1:0][31:0] addr_r  = '0;
  logic [N-1:0]       cmd_r   = '0;
  logic [N-1:0][31:0] wdata_r = '0;
  int                 gap[N];
  int                 life[N];
  bit                 rearm[N];
  bit                 auto_m  = 1'b0;
  bit                 rst_req = 1'b1;

  int          force_delay = -1;
  bit          force_rd    = 1'b0;
  logic [31:0] frd         = '0;
  int          s_age       = 0;
  int          s_delay     = 0;

  int          ack_cnt[N];
  logic [31:0] last_rd[N];
  int          tmo_cnt = 0;
  int          grant_log[$];

  // reference model: transaction view of the slave port
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_grant = 0;
  int          m_ptr  = 0;
  logic [31:0] m_addr, m_wdata;
  logic        m_cmd;
  logic [1:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 1000;
    if (r == 1) return TMO;
    return $urandom_range(1, 5);
  endfunction

  task automatic new_req(input int i);
    req_r[i]   = 1'b1;
    cmd_r[i]   = 1'($urandom_range(0, 1));
    wdata_r[i] = $urandom();
    addr_r[i]  = $urandom();
    if ($urandom_range(0, 3) == 0) begin
      addr_r[i][31:28] = 4'($urandom_range(1, 15));
      life[i] = $urandom_range(3, 15);
    end else begin
      addr_r[i][31:28] = 4'h0;
      life[i] = 0;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic c);
    req_r[i] = 1'b1; addr_r[i] = a; cmd_r[i] = c; wdata_r[i] = $urandom(); life[i] = 0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; last_rd[i] = '0; end
    tmo_cnt = 0;
    grant_log.delete();
  endtask

  // ---------------- one cycle: drive, check, model, agents ----------------
  task automatic step();
    logic [N-1:0] exp_ack;
    logic [31:0]  exp_rd;
    bit           exp_done;
    int           obs;
    @(negedge clk);
    rst       = rst_req;
    m_s_req   = req_r;
    m_s_addr  = addr_r;
    m_s_cmd   = cmd_r;
    m_s_wdata = wdata_r;
    if (rst_req) begin
      s_age = 0; sl_ack = 1'b0;
    end else if (sl_req) begin
      s_age++;
      if (s_age == 1) s_delay = (force_delay >= 0) ? force_delay : pick_delay();
      sl_ack = (s_age == s_delay);
    end else begin
      s_age  = 0;
      sl_ack = ($urandom_range(0, 5) == 0);
    end
    sl_rdata = force_rd ? frd : $urandom();
    #1;
    if (rst_req) begin
      m_busy = 1'b0; m_ptr = 0; m_age = 0;
      exp_q.delete();
    end else begin
      exp_done = m_busy && (sl_ack || m_age == TMO);
      exp_ack  = exp_done ? (N'(1) << m_grant) : '0;
      exp_rd   = !exp_done ? 32'h0 : (sl_ack ? sl_rdata : 32'hDEAD_BEEF);
      check("sl_req", 32'(sl_req), 32'(m_busy));
      check("state", 32'(dbg_state), 32'(m_busy));
      if (m_busy) begin
        check("sl_addr", sl_addr, m_addr);
        check("sl_cmd", 32'(sl_cmd), 32'(m_cmd));
        check("sl_wdata", sl_wdata, m_wdata);
      end
      check("s_m_ack", 32'(s_m_ack), 32'(exp_ack));
      check("s_m_rdata", s_m_rdata, exp_rd);
      check("timeout", 32'(timeout), 32'(exp_done && !sl_ack));
      obs = -1;
      for (int i = 0; i < N; i++) begin
        if (s_m_ack[i]) begin
          ack_cnt[i]++; last_rd[i] = s_m_rdata; grant_log.push_back(i); obs = i;
        end
      end
      if (obs >= 0) begin
        if (exp_q.size() == 0) check("sb_unexpected_ack", 32'(obs), 32'hFFFF_FFFF);
        else check("sb_grant", 32'(obs), 32'(exp_q.pop_front()));
      end
      if (timeout) tmo_cnt++;
      if (exp_done) begin
        m_busy = 1'b0;
        m_ptr  = (m_grant + 1) % N;
      end else if (m_busy) begin
        m_age++;
      end else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!m_busy && m_s_req[i] && m_s_addr[i][31:28] == 4'h0) begin
            m_busy = 1'b1; m_age = 1; m_grant = i;
            m_addr = m_s_addr[i]; m_cmd = m_s_cmd[i]; m_wdata = m_s_wdata[i];
            exp_q.push_back(2'(i));
          end
        end
      end
    end
    // master agents
    for (int i = 0; i < N; i++) begin
      if (!rst_req && s_m_ack[i]) begin
        req_r[i] = 1'b0;
        gap[i]   = rearm[i] ? 0 : $urandom_range(1, 4);
      end else if (!req_r[i]) begin
        if (gap[i] > 0) gap[i]--;
        else if (rearm[i]) req_r[i] = 1'b1;
        else if (auto_m && $urandom_range(0, 2) == 0) new_req(i);
      end else if (life[i] > 0) begin
        life[i]--;
        if (life[i] == 0) req_r[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    run(2);
    rst_req = 1'b0;
    run(1);
    check("rst_ptr", 32'(dbg_ptr), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin gap[i] = 0; life[i] = 0; rearm[i] = 1'b0; end
    clear_stats();
    do_reset();

    // single read from M1
    force_delay = 3; force_rd = 1'b1; frd = 32'h1234_5678;
    set_req(1, 32'h0000_0010, 1'b0);
    run(10);
    check("t1_acks", 32'(ack_cnt[1]), 32'd1);
    check("t1_rdata", last_rd[1], 32'h1234_5678);
    check("t1_other_acks", 32'(ack_cnt[0] + ack_cnt[2] + ack_cnt[3]), 32'd0);

    // round robin with all masters writing continuously
    do_reset();
    clear_stats();
    force_delay = 1; force_rd = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 32'h0000_0000 + 32'(i), 1'b1);
      rearm[i] = 1'b1;
    end
    run(10);
    for (int i = 0; i < N; i++) rearm[i] = 1'b0;
    run(12);
    check("t2_count", 32'(grant_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) check("t2_order", 32'(grant_log[k]), 32'(rr_exp[k]));

    // address filter
    clear_stats();
    set_req(2, 32'h1000_0000, 1'b0);
    run(20);
    check("t3_state", 32'(dbg_state), 32'd0);
    check("t3_acks", 32'(ack_cnt[2]), 32'd0);
    req_r[2] = 1'b0;
    run(2);

    // watchdog timeout on M3
    clear_stats();
    force_delay = 1000;
    set_req(3, 32'h0000_0030, 1'b0);
    run(70);
    check("t4_tmo", 32'(tmo_cnt), 32'd1);
    check("t4_acks", 32'(ack_cnt[3]), 32'd1);
    check("t4_rdata", last_rd[3], 32'hDEAD_BEEF);

    // real ack on the watchdog's last cycle
    clear_stats();
    force_delay = TMO; force_rd = 1'b1; frd = 32'hA5A5_A5A5;
    set_req(3, 32'h0000_0034, 1'b0);
    run(70);
    check("t5_tmo", 32'(tmo_cnt), 32'd0);
    check("t5_acks", 32'(ack_cnt[3]), 32'd1);
    check("t5_rdata", last_rd[3], 32'hA5A5_A5A5);
    force_rd = 1'b0;

    // reset mid-transaction: pointer at 3 before, M2 must win after
    force_delay = 1;
    set_req(2, 32'h0000_0050, 1'b1);
    run(6);
    check("t6_ptr_pre", 32'(dbg_ptr), 32'd3);
    force_delay = 1000;
    set_req(3, 32'h0000_0060, 1'b0);
    run(5);
    set_req(2, 32'h0000_0070, 1'b1);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    force_delay = 2;
    clear_stats();
    run(1);
    check("t6_ptr_post", 32'(dbg_ptr), 32'd0);
    run(12);
    check("t6_count", 32'(grant_log.size() >= 1), 32'd1);
    if (grant_log.size() >= 1) check("t6_first", 32'(grant_log[0]), 32'd2);
    check("t6_m3_acks", 32'(ack_cnt[3]), 32'd1);

    // random traffic with a reset in the middle
    force_delay = -1;
    auto_m = 1'b1;
    run(1500);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    run(1500);
    auto_m = 1'b0;
    run(200);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
